// File: rtl/audio_i2s_tx.sv
// Purpose     : serialise signed stereo PCM into an I2S stream (sclk, lrck, MSB-first data).
// Latency     : a sample loaded into an empty hold before a frame boundary (FB) has its left MSB on
//               audio_dac 1+MCLK_DIV clk cycles after that FB.
// Backpressure: none. There is a one-entry hold buffer. An unconsumed hold that is overwritten pulses overrun.
//               A frame that starts with the hold empty repeats the last sample and pulses underrun.
//
// Ports:
//   clk                 audio clock; the same clock also serves as the DAC master clock
//   reset               asynchronous, active-high; every counter, buffer and output clears to 0
//   sample_l/sample_r   two's complement PCM words, captured on a sample_valid strobe
//   sample_valid        1-cycle capture strobe
//   mute                sampled at each frame boundary; when latched high the next frame is silent
//   audio_sclk          bit clock = clk / MCLK_DIV
//   audio_lrck          0 = left slot, 1 = right slot
//   audio_dac           serial data. Slot bit 0 is 0, bits 1..SAMPLE_WIDTH carry the word MSB first,
//                       and the remaining slot bits are 0
//   frame_start         1-cycle pulse in the first cycle of every frame
//   overrun/underrun    1-cycle event pulses; they are not sticky
module audio_i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32,
    parameter int MCLK_DIV     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    input  logic                    mute,
    output logic                    audio_sclk,
    output logic                    audio_lrck,
    output logic                    audio_dac,
    output logic                    frame_start,
    output logic                    overrun,
    output logic                    underrun
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int DIV_W  = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
    localparam int SLOT_W = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;
    localparam int CNT_W  = SLOT_W + 1;           // bit position within a full L+R frame
    localparam int KX_W   = SLOT_W + 1;           // slot index widened by one bit for subtraction
    localparam int IDX_W  = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;   // 2*SLOT_BITS is a power of two
    localparam logic [KX_W-1:0]  SW_EXT   = KX_W'(SAMPLE_WIDTH);

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] l;
        logic [SAMPLE_WIDTH-1:0] r;
    } stereo_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q,        div_d;
    logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic             sclk_q,       sclk_d;
    logic             lrck_q,       lrck_d;
    logic             dac_q,        dac_d;
    logic             frame_start_q, frame_start_d;
    logic             overrun_q,    overrun_d;
    logic             underrun_q,   underrun_d;
    stereo_t          hold_q,       hold_d;
    logic             hold_full_q,  hold_full_d;
    stereo_t          act_q,        act_d;
    logic             mute_q,       mute_d;

    // Combinational helpers
    logic                    wrap;       // last clk of an sclk period
    logic                    fb;         // last clk of the whole frame
    stereo_t                 in_word;
    logic [SLOT_W-1:0]       k;          // bit index inside the current slot
    logic [KX_W-1:0]         k_ext;
    logic                    k_in_word;
    logic [IDX_W-1:0]        word_idx;
    logic [SAMPLE_WIDTH-1:0] chan_word;
    logic                    dac_bit;

    // ------------------------------------------------------------------
    // Timing chain: clk -> sclk period -> slot bit -> frame
    // ------------------------------------------------------------------
    always_comb begin
        wrap      = (div_q == DIV_MAX);
        div_d     = wrap ? '0 : div_q + DIV_W'(1);
        fb        = wrap && (bit_cnt_q == CNT_MAX);
        // Wraps naturally from CNT_MAX back to 0.
        bit_cnt_d = wrap ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;

        // sclk is high for the upper half of the divider count. Data moves on the
        // divider wrap, which is half a bit period away from the sclk rising edge.
        sclk_d    = (div_q >= DIV_HALF);
        lrck_d    = bit_cnt_d[CNT_W-1];
    end

    // ------------------------------------------------------------------
    // Hold buffer / active word management
    // ------------------------------------------------------------------
    always_comb begin
        in_word.l     = sample_l;
        in_word.r     = sample_r;

        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        act_d         = act_q;
        mute_d        = mute_q;
        overrun_d     = 1'b0;
        underrun_d    = 1'b0;
        frame_start_d = fb;

        if (fb) begin
            mute_d = mute;
            if (hold_full_q) begin
                // The buffered sample goes on air. A coincident new sample refills the hold.
                act_d = hold_q;
                if (sample_valid) begin
                    hold_d      = in_word;
                    hold_full_d = 1'b1;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (sample_valid) begin
                // The hold is empty, so a coincident sample goes on air directly.
                act_d = in_word;
            end else begin
                // Nothing is queued, so the previous sample repeats.
                underrun_d = 1'b1;
            end
        end else if (sample_valid) begin
            overrun_d   = hold_full_q;
            hold_d      = in_word;
            hold_full_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serial data. Selection uses next-state values so that the bit registered on a
    // wrap belongs to the slot position that starts in the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        k         = bit_cnt_d[SLOT_W-1:0];
        k_ext     = {1'b0, k};
        k_in_word = (k != '0) && (k_ext <= SW_EXT);
        word_idx  = IDX_W'(SW_EXT - k_ext);
        chan_word = bit_cnt_d[CNT_W-1] ? act_d.r : act_d.l;
        dac_bit   = k_in_word && !mute_d && chan_word[word_idx];
        dac_d     = wrap ? dac_bit : dac_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            bit_cnt_q     <= '0;
            sclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            dac_q         <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            act_q         <= '0;
            mute_q        <= 1'b0;
        end else begin
            div_q         <= div_d;
            bit_cnt_q     <= bit_cnt_d;
            sclk_q        <= sclk_d;
            lrck_q        <= lrck_d;
            dac_q         <= dac_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            underrun_q    <= underrun_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            act_q         <= act_d;
            mute_q        <= mute_d;
        end
    end

    assign audio_sclk  = sclk_q;
    assign audio_lrck  = lrck_q;
    assign audio_dac   = dac_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;

endmodule
